// File: rtl/regfile_mp_sb.sv
// Purpose: parameterised register file, NR read ports, 2 write ports, write-through bypass, busy scoreboard.
// Latency: reads are combinational (0 cycles); writes, marks and busy_cnt update on the next rising clk edge.
// Backpressure: none; every write and mark is accepted. The hazard unit stalls on rbusy instead.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   raddr / rdata / rbusy flattened read ports (port i at [i*AW +: AW] / [i*DW +: DW] / [i])
//   we0, wa0, wd0         write port 0, the pipeline writeback
//   we1, wa1, wd1         write port 1, the late MDU writeback; also clears the busy bit
//   mark_en, mark_addr    sets the busy bit when a multi-cycle op issues
//   busy_cnt              number of registers currently busy
module regfile_mp_sb #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             mark_en,
    input  logic [AW-1:0]    mark_addr,
    output logic [AW:0]      busy_cnt
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    logic wr0_vld;
    logic wr1_vld;
    logic wr1_store;
    logic mark_vld;
    logic cnt_inc;
    logic cnt_dec;
    logic [AW-1:0] ra;

    // Register 0 is hard-wired: writes, clears and marks to it are dropped here.
    assign wr0_vld  = we0 && (wa0 != '0);
    assign wr1_vld  = we1 && (wa1 != '0);
    assign mark_vld = mark_en && (mark_addr != '0);

    // Port 0 owns the data on an address collision. Port 1 still clears busy
    // through wr1_vld, because the MDU result has retired either way.
    assign wr1_store = wr1_vld && !(wr0_vld && (wa0 == wa1));

    // Scoreboard next state. The mark is applied after the clear, so a newly
    // issued op wins over a retiring one on the same register.
    always_comb begin
        busy_nxt = busy;
        if (wr1_vld) begin
            busy_nxt[wa1] = 1'b0;
        end
        if (mark_vld) begin
            busy_nxt[mark_addr] = 1'b1;
        end
    end

    // busy_cnt tracks the transitions, not a popcount of the whole vector.
    // A rising bit comes only from a mark on a free register. A falling bit
    // comes only from a clear on a busy register that is not re-marked in the
    // same cycle. With at most one of each per cycle, the count moves by at
    // most one. It is bounded by the DEPTH-1 markable registers.
    assign cnt_inc = mark_vld && !busy[mark_addr];
    assign cnt_dec = wr1_vld && busy[wa1] && !(mark_vld && (mark_addr == wa1));

    always_comb begin
        cnt_nxt = busy_cnt;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_nxt = busy_cnt + CNT_ONE;
            2'b01:   cnt_nxt = busy_cnt - CNT_ONE;
            default: cnt_nxt = busy_cnt;
        endcase
    end

    // Read ports. While reset is high, the outputs are forced to zero even if
    // a write is presented, so nothing from a discarded cycle leaks out.
    // rbusy ignores a same-cycle mark. It honours a same-cycle port-1
    // writeback, whose data is already on the bypass path.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NR; i++) begin
            ra = raddr[i*AW +: AW];
            if (!reset && (ra != '0)) begin
                if (we0 && (wa0 == ra)) begin
                    rdata[i*DW +: DW] = wd0;
                end else if (we1 && (wa1 == ra)) begin
                    rdata[i*DW +: DW] = wd1;
                end else begin
                    rdata[i*DW +: DW] = mem[ra];
                end
                rbusy[i] = busy[ra] && !(we1 && (wa1 == ra));
            end
        end
    end

    // State. Port 1 is written first and port 0 last, so port 0 takes priority
    // on a collision. wr1_store already excludes that case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr1_store) begin
                mem[wa1] <= wd1;
            end
            if (wr0_vld) begin
                mem[wa0] <= wd0;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Purpose: self-checking bench for regfile_mp_sb (default 32x32x2R, plus a 16x64x4R build).
// Latency: expects zero-latency reads and one-edge latency for writes, busy bits and busy_cnt.
// Backpressure: none in the design, so the stimulus never waits on the DUT.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;

    // Default build: DW=32, AW=5, NR=2.
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we0, we1, mark_en;
    logic [4:0]  wa0, wa1, mark_addr;
    logic [31:0] wd0, wd1;
    logic [5:0]  busy_cnt;

    // Wide build: DW=64, AW=4, NR=4.
    logic [15:0]  b_raddr;
    logic [255:0] b_rdata;
    logic [3:0]   b_rbusy;
    logic         b_we0, b_we1, b_mark_en;
    logic [3:0]   b_wa0, b_wa1, b_mark_addr;
    logic [63:0]  b_wd0, b_wd1;
    logic [4:0]   b_busy_cnt;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_sb u_dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .mark_en(mark_en), .mark_addr(mark_addr), .busy_cnt(busy_cnt)
    );

    regfile_mp_sb #(.DW(64), .AW(4), .NR(4)) u_wide (
        .clk(clk), .reset(reset), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .mark_en(b_mark_en), .mark_addr(b_mark_addr), .busy_cnt(b_busy_cnt)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of the default build: plain arrays of contents and busy flags.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                m_mem[k]  <= '0;
                m_busy[k] <= 1'b0;
            end
        end else begin
            if (we1 && wa1 != 5'd0) begin
                m_mem[wa1]  <= wd1;
                m_busy[wa1] <= 1'b0;
            end
            if (we0 && wa0 != 5'd0) m_mem[wa0] <= wd0;
            if (mark_en && mark_addr != 5'd0) m_busy[mark_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'd0;
        if (we0 && wa0 == a) return wd0;
        if (we1 && wa1 == a) return wd1;
        return m_mem[a];
    endfunction

    function automatic logic m_rb(input logic [4:0] a);
        if (reset || a == 5'd0) return 1'b0;
        if (we1 && wa1 == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int k = 0; k < 32; k++) if (m_busy[k]) c++;
        return c;
    endfunction

    // Every-cycle compare of the default build against the model, mid low phase.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("model_rdata%0d", p), 256'(rdata[p*32 +: 32]), 256'(m_rd(raddr[p*5 +: 5])));
                check($sformatf("model_rbusy%0d", p), 256'(rbusy[p]), 256'(m_rb(raddr[p*5 +: 5])));
            end
            check("model_busy_cnt", 256'(busy_cnt), 256'(m_cnt()));
        end
    end

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        mark_en = 1'b0; mark_addr = '0;
        b_we0 = 1'b0; b_wa0 = '0; b_wd0 = '0;
        b_we1 = 1'b0; b_wa1 = '0; b_wd1 = '0;
        b_mark_en = 1'b0; b_mark_addr = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic set_ra(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        raddr = '0;
        b_raddr = '0;

        @(negedge clk);
        #3;
        check("reset_rdata", 256'(rdata), 256'h0);
        check("reset_rbusy", 256'(rbusy), 256'h0);
        check("reset_cnt", 256'(busy_cnt), 256'h0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: write x5, mark x7, then an asynchronous reset mid-cycle.
        tick(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; mark_en = 1; mark_addr = 7;
        set_ra(0, 5); set_ra(1, 7);
        #3;
        check("t1_bypass", 256'(rdata[31:0]), 256'hDEADBEEF);
        check("t1_mark_not_visible", 256'(rbusy[1]), 256'h0);
        tick();
        #3;
        check("t1_stored", 256'(rdata[31:0]), 256'hDEADBEEF);
        check("t1_busy7", 256'(rbusy[1]), 256'h1);
        check("t1_cnt1", 256'(busy_cnt), 256'h1);
        #1;
        reset = 1; we0 = 1; wa0 = 5; wd0 = 32'h1; mark_en = 1; mark_addr = 9;
        #1;
        check("t1_rst_rdata", 256'(rdata), 256'h0);
        check("t1_rst_rbusy", 256'(rbusy), 256'h0);
        check("t1_rst_cnt", 256'(busy_cnt), 256'h0);
        tick(); reset = 0; set_ra(0, 5); set_ra(1, 9);
        #3;
        check("t1_post_x5", 256'(rdata[31:0]), 256'h0);
        check("t1_post_busy9", 256'(rbusy[1]), 256'h0);
        check("t1_post_cnt", 256'(busy_cnt), 256'h0);

        // 2: port 0 bypass and storage.
        tick(); we0 = 1; wa0 = 3; wd0 = 32'h12345678; set_ra(0, 3);
        #3;
        check("t2_bypass", 256'(rdata[31:0]), 256'h12345678);
        tick();
        #3;
        check("t2_stored", 256'(rdata[31:0]), 256'h12345678);

        // 3: dual write collision on a busy register.
        tick(); mark_en = 1; mark_addr = 9; set_ra(0, 9); set_ra(1, 9);
        tick();
        #3;
        check("t3_busy9", 256'(rbusy), 256'h3);
        check("t3_cnt1", 256'(busy_cnt), 256'h1);
        tick(); we0 = 1; wa0 = 9; wd0 = 32'hAAAA; we1 = 1; wa1 = 9; wd1 = 32'h5555;
        #3;
        check("t3_bypass_p0", 256'(rdata[31:0]), 256'hAAAA);
        check("t3_bypass_p1", 256'(rdata[63:32]), 256'hAAAA);
        check("t3_unbusy", 256'(rbusy), 256'h0);
        tick();
        #3;
        check("t3_stored", 256'(rdata[31:0]), 256'hAAAA);
        check("t3_cnt0", 256'(busy_cnt), 256'h0);

        // 4: mark, then port 1 writeback.
        tick(); mark_en = 1; mark_addr = 4; set_ra(0, 4); set_ra(1, 4);
        tick();
        #3;
        check("t4_busy", 256'(rbusy[1]), 256'h1);
        check("t4_cnt1", 256'(busy_cnt), 256'h1);
        tick(); we1 = 1; wa1 = 4; wd1 = 32'h77;
        #3;
        check("t4_wb_rbusy", 256'(rbusy[1]), 256'h0);
        check("t4_wb_rdata", 256'(rdata[31:0]), 256'h77);
        tick();
        #3;
        check("t4_cnt0", 256'(busy_cnt), 256'h0);
        check("t4_stored", 256'(rdata[31:0]), 256'h77);

        // 5: mark against a same-register clear, then against a different-register clear.
        tick(); mark_en = 1; mark_addr = 6; set_ra(0, 8); set_ra(1, 6);
        tick(); mark_en = 1; mark_addr = 6; we1 = 1; wa1 = 6; wd1 = 32'h66;
        #3;
        check("t5_same_rbusy", 256'(rbusy[1]), 256'h0);
        check("t5_same_rdata", 256'(rdata[63:32]), 256'h66);
        tick();
        #3;
        check("t5_still_busy", 256'(rbusy[1]), 256'h1);
        check("t5_cnt_same", 256'(busy_cnt), 256'h1);
        tick(); mark_en = 1; mark_addr = 8; we1 = 1; wa1 = 6; wd1 = 32'h606;
        tick();
        #3;
        check("t5_x8_busy", 256'(rbusy[0]), 256'h1);
        check("t5_x6_free", 256'(rbusy[1]), 256'h0);
        check("t5_cnt_net0", 256'(busy_cnt), 256'h1);
        tick(); mark_en = 1; mark_addr = 8; we1 = 1; wa1 = 5; wd1 = 32'h5;
        tick();
        #3;
        check("t5_remark_clrfree", 256'(busy_cnt), 256'h1);

        // Count saturation: mark every register, then retire them all.
        for (int a = 1; a < 32; a++) begin
            tick(); mark_en = 1; mark_addr = 5'(a); set_ra(0, 5'(a)); set_ra(1, 5'(32 - a));
        end
        tick(); mark_en = 1; mark_addr = 0;
        #3;
        check("cnt_full", 256'(busy_cnt), 256'd31);
        tick();
        #3;
        check("cnt_full_x0", 256'(busy_cnt), 256'd31);
        for (int a = 1; a < 32; a++) begin
            tick(); we1 = 1; wa1 = 5'(a); wd1 = 32'(a * 3); set_ra(0, 5'(a)); set_ra(1, 5'(a - 1));
        end
        tick();
        #3;
        check("cnt_empty", 256'(busy_cnt), 256'd0);

        // 6: register 0 on the default build.
        tick(); we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 1; wa1 = 0; wd1 = 32'hFFFF;
        mark_en = 1; mark_addr = 0; set_ra(0, 0); set_ra(1, 0);
        #3;
        check("t6_x0_rdata", 256'(rdata), 256'h0);
        check("t6_x0_rbusy", 256'(rbusy), 256'h0);
        tick();
        #3;
        check("t6_x0_cnt", 256'(busy_cnt), 256'h0);
        check("t6_x0_after", 256'(rdata), 256'h0);

        // 6: wide build, register 0 then flattened slice placement.
        tick(); b_we0 = 1; b_wa0 = 0; b_wd0 = 64'hFFFF; b_we1 = 1; b_wa1 = 0; b_wd1 = 64'hFFFF;
        b_mark_en = 1; b_mark_addr = 0; b_raddr = 16'h0000;
        #3;
        check("w_x0_rdata", b_rdata, 256'h0);
        check("w_x0_rbusy", 256'(b_rbusy), 256'h0);
        tick(); b_we0 = 1; b_wa0 = 1; b_wd0 = 64'h1111_2222_3333_4444;
        b_we1 = 1; b_wa1 = 2; b_wd1 = 64'h5555_6666_7777_8888;
        b_mark_en = 1; b_mark_addr = 3;
        #3;
        check("w_x0_cnt", 256'(b_busy_cnt), 256'h0);
        tick(); b_we0 = 1; b_wa0 = 3; b_wd0 = 64'h9999_AAAA_BBBB_CCCC;
        b_raddr = {4'd0, 4'd3, 4'd2, 4'd1};
        #3;
        check("w_slices", b_rdata, {64'h0, 64'h9999_AAAA_BBBB_CCCC,
                                    64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});
        check("w_rbusy", 256'(b_rbusy), 256'h4);
        check("w_cnt1", 256'(b_busy_cnt), 256'h1);
        tick(); b_we1 = 1; b_wa1 = 15; b_wd1 = 64'hDDDD_EEEE_FFFF_0001;
        b_raddr = {4'd15, 4'd3, 4'd3, 4'd1};
        #3;
        check("w_port3_top", 256'(b_rdata[255:192]), 256'hDDDD_EEEE_FFFF_0001);
        check("w_same_addr", 256'(b_rdata[191:128]), 256'(b_rdata[127:64] ^ 64'h0) & 256'hFFFF_FFFF_FFFF_FFFF);
        check("w_port2_x3", 256'(b_rdata[191:128]), 256'h9999_AAAA_BBBB_CCCC);
        check("w_rbusy_dup", 256'(b_rbusy), 256'h6);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
